// File: rtl/count_bcd_display.sv
// 13-bit binary to 4-digit BCD converter (serial double-dabble, 13 steps) with seven-segment drive.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits on hex3..hex1.
module count_bcd_display #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] count,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  localparam int unsigned CNT_W  = 13;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned STEP_W = 4;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CNT_W);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_POST  = 2'd2
  } state_e;

  // Active-high segment pattern (bit0 = a .. bit6 = g), then polarity applied.
  function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] nib, input logic blank);
    logic [SEG_W-1:0] lit;
    lit = '0;
    if (!blank) begin
      case (nib)
        4'd0:    lit = 7'b0111111;
        4'd1:    lit = 7'b0000110;
        4'd2:    lit = 7'b1011011;
        4'd3:    lit = 7'b1001111;
        4'd4:    lit = 7'b1100110;
        4'd5:    lit = 7'b1101101;
        4'd6:    lit = 7'b1111101;
        4'd7:    lit = 7'b0000111;
        4'd8:    lit = 7'b1111111;
        4'd9:    lit = 7'b1101111;
        default: lit = '0;
      endcase
    end
    seg_encode = SEG_ACTIVE_LOW ? ~lit : lit;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] nib);
    add3 = (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  state_e             state_q;
  logic [CNT_W-1:0]   sr_q;
  logic [BCD_W-1:0]   acc_q;
  logic [STEP_W-1:0]  step_q;
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [SEG_W-1:0]   hex0_q;
  logic [SEG_W-1:0]   hex1_q;
  logic [SEG_W-1:0]   hex2_q;
  logic [SEG_W-1:0]   hex3_q;

  logic [11:0]        acc_adj_c;
  logic [BCD_W-1:0]   acc_d;
  logic [CNT_W-1:0]   sr_d;
  logic [STEP_W-1:0]  step_d;
  logic               blank1_c;
  logic               blank2_c;
  logic               blank3_c;

  // One double-dabble step. Inputs never exceed 8191, so the thousands nibble
  // is at most 4 before any shift and needs no add-3 correction.
  always_comb begin
    acc_adj_c = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};
    acc_d     = {acc_q[14:12], acc_adj_c, sr_q[CNT_W-1]};
    sr_d      = {sr_q[CNT_W-2:0], 1'b0};
    step_d    = step_q + STEP_W'(1);
  end

  // Leading-zero flags cascade from the thousands digit downwards.
  always_comb begin
    blank3_c = LZB_EN && (acc_q[15:12] == 4'd0);
    blank2_c = blank3_c && (acc_q[11:8] == 4'd0);
    blank1_c = blank2_c && (acc_q[7:4] == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      hex0_q  <= seg_encode(4'd0, 1'b0);
      hex1_q  <= seg_encode(4'd0, LZB_EN);
      hex2_q  <= seg_encode(4'd0, LZB_EN);
      hex3_q  <= seg_encode(4'd0, LZB_EN);
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            sr_q    <= count;
            acc_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_q  <= acc_d;
          sr_q   <= sr_d;
          step_q <= step_d;
          if (step_d == LAST_STEP) begin
            state_q <= S_POST;
          end
        end
        S_POST: begin
          bcd_q   <= acc_q;
          hex0_q  <= seg_encode(acc_q[3:0], 1'b0);
          hex1_q  <= seg_encode(acc_q[7:4], blank1_c);
          hex2_q  <= seg_encode(acc_q[11:8], blank2_c);
          hex3_q  <= seg_encode(acc_q[15:12], blank3_c);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign hex0 = hex0_q;
  assign hex1 = hex1_q;
  assign hex2 = hex2_q;
  assign hex3 = hex3_q;

endmodule

// File: doc/count_bcd_display.md
COUNT_BCD_DISPLAY -- requirements
Module: count_bcd_display

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 1; 1 = segment lit when its bit is 0, 0 = segment lit when its bit is 1.
REQ-002 clk  input  1  single clock; all state SHALL change on posedge clk only.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 count  input  13  binary value from the upstream 13-bit pausable counter (0..8191).
REQ-005 load  input  1  request to sample count and start a conversion.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when a new result is posted on bcd and hex0..hex3.
REQ-008 bcd  output  16  packed BCD result, [15:12] thousands .. [3:0] units.
REQ-009 hex0, hex1, hex2, hex3  output  7 each  seven-segment drive for units, tens, hundreds and thousands; bit0 = a .. bit6 = g.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and POST.
- Transitions: IDLE->SHIFT on load; SHIFT->POST after the 13th shift; POST->IDLE unconditionally.
REQ-011 In IDLE with load=1, the block SHALL capture count into a 13-bit shift register, clear a 16-bit BCD accumulator and a 4-bit shift counter, and enter SHIFT.
REQ-012 Each SHIFT cycle SHALL perform one double-dabble step.
- First add 3 to every accumulator nibble that is >=5.
- Then shift {accumulator, shift register} left by 1.
- Then increment the shift counter.
REQ-013 SHIFT SHALL last exactly 13 cycles; the step in which the counter reaches 13 SHALL move the FSM to POST.
REQ-014 In POST, bcd and hex0..hex3 SHALL be updated from the accumulator and done SHALL be high for exactly that one cycle.
REQ-015 Latency: load sampled at edge N -> done high and outputs valid in the cycle after edge N+14; the next load is accepted at edge N+15 at the earliest.
REQ-016 busy SHALL be 1 in SHIFT and POST and 0 in IDLE.
REQ-017 load while busy=1 SHALL be ignored; there is no queueing.
REQ-018 load held high continuously SHALL start a new conversion every 15 cycles, each sampling count at its own start edge.
REQ-019 bcd and hex0..hex3 SHALL hold their last posted value between done pulses, including while a new conversion runs.
REQ-020 Segment encoding for digits 0-9 SHALL use the standard patterns, with blank = all segments off.
- Active-low examples: 0 = 1000000, 1 = 1111001, 8 = 0000000.
- Polarity is inverted when SEG_ACTIVE_LOW=0.
REQ-021 Nibble values 10-15 cannot occur; if forced, the digit SHALL be driven blank.
REQ-022 Changes on count after the sampling edge SHALL NOT affect the conversion in progress.

Reset
REQ-023 reset=1 at a clock edge SHALL force IDLE, busy=0, done=0, bcd=0, and the accumulator, shift register and shift counter to 0.
- The same edge SHALL drive hex0..hex3 to the pattern for digit 0.
REQ-024 reset SHALL take priority over load and over an in-progress conversion.
- A conversion aborted by reset SHALL NOT produce a done pulse or update the outputs.
REQ-025 load sampled in the same cycle as reset SHALL be ignored.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
- Defined: at POST, hex3, then hex2, then hex1 are driven blank while they and every higher digit are zero; hex0 always shows its digit.
- Defined: the reset value of hex3..hex1 becomes blank, with hex0 = 0.
- Undefined: all four digits always show their value, including leading zeros.
- bcd SHALL be identical in both builds.

Verification
REQ-027 count=8191, pulse load -> done 14 cycles later; bcd=0x8191; hex3..hex0 = 8,1,9,1.
REQ-028 count=0, load -> bcd=0x0000; without macro all digits show 0; with macro hex3..hex1 blank and hex0 shows 0.
REQ-029 count=1000, load, then load pulses and count=5 during busy -> single done, bcd=0x1000, extra loads ignored.
REQ-030 count=4095, load, reset at the 6th SHIFT cycle -> busy=0, bcd=0, no done pulse; a later load of 4095 gives bcd=0x4095.
REQ-031 load held high with count incrementing by 1 from 0 -> done every 15 cycles; each bcd equals count at its sampling edge.
REQ-032 SEG_ACTIVE_LOW=0 with count=8 -> hex0 = 1111111 and hex1..hex3 = the active-high pattern for 0 (0111111, without macro).
